// File: rtl/trace_drain_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_drain_serializer : pops trace words and frames them as SYNC,SEQ,data,CSUM
// Revision: 1.0
// ---------------------------------------------------------------------------
module trace_drain_serializer #(
  parameter int          Fpay      = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            drain_en,
  input  logic            fifo_empty,
  output logic            fifo_rd,
  input  logic [Fpay-1:0] fifo_dout,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic [15:0]     frame_cnt
);

  localparam int NB = Fpay / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_LOAD = 3'd2,
    S_SYNC = 3'd3,
    S_SEQ  = 3'd4,
    S_DATA = 3'd5,
    S_CSUM = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic            fifo_rd_q, fifo_rd_d;
  logic            busy_q, busy_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      seq_q, seq_d;
  logic [7:0]      csum_q, csum_d;
  logic [Fpay-1:0] word_q, word_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            accept;

  assign accept = tx_valid_q & tx_ready;

  always_comb begin
    state_d     = state_q;
    fifo_rd_d   = 1'b0;
    busy_d      = busy_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    seq_d       = seq_q;
    csum_d      = csum_q;
    word_d      = word_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (drain_en && !fifo_empty) begin
          fifo_rd_d = 1'b1;
          state_d   = S_POP;
        end
      end
      S_POP: begin
        busy_d  = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        word_d     = fifo_dout;
        csum_d     = 8'h00;
        idx_d      = '0;
        tx_data_d  = SYNC_BYTE;
        tx_valid_d = 1'b1;
        state_d    = S_SYNC;
      end
      S_SYNC: begin
        if (accept) begin
          tx_data_d = seq_q;
          csum_d    = seq_q;
          state_d   = S_SEQ;
        end
      end
      S_SEQ: begin
        // The word register shifts left so the next byte is always at the top.
        if (accept) begin
          tx_data_d = word_q[Fpay-1 -: 8];
          word_d    = word_q << 8;
          idx_d     = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ tx_data_q;
          if (idx_q == LAST_IDX) begin
            tx_data_d = csum_q ^ tx_data_q;
            state_d   = S_CSUM;
          end else begin
            tx_data_d = word_q[Fpay-1 -: 8];
            word_d    = word_q << 8;
            idx_d     = idx_q + IW'(1);
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          seq_d      = seq_q + 8'd1;
          if (frame_cnt_q != 16'hFFFF) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fifo_rd_q   <= 1'b0;
      busy_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      seq_q       <= 8'h00;
      csum_q      <= 8'h00;
      word_q      <= '0;
      idx_q       <= '0;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      fifo_rd_q   <= fifo_rd_d;
      busy_q      <= busy_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      seq_q       <= seq_d;
      csum_q      <= csum_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fifo_rd   = fifo_rd_q;
  assign busy      = busy_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_drain_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_trace_drain_serializer : directed frame checks with a trace FIFO model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_trace_drain_serializer;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        drain_en;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [31:0] fifo_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] frame_cnt;

  trace_drain_serializer #(.Fpay(32), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .drain_en  (drain_en),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_dout (fifo_dout),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          rd_cnt   = 0;
  int          rd_time_last = 0;
  int          rd_time_prev = 0;
  logic [31:0] fq[$];
  logic [7:0]  rxq[$];
  logic [7:0]  exp_seq = 8'h00;
  bit          mon_en = 1'b1;
  bit          stall_mode = 1'b0;
  bit          ready_lvl = 1'b0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [7:0]  pd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (stall_mode) tx_ready = ($urandom_range(0, 2) == 0);
    else            tx_ready = ready_lvl;
  end

  // FIFO model and byte monitor, both sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_rd === 1'b1) begin
      rd_cnt++;
      rd_time_prev = rd_time_last;
      rd_time_last = cyc;
      chk("pop_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) fifo_dout = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
    if (mon_en) begin
      if (pv && !pr) begin
        chk("stall_valid", 32'(tx_valid), 32'd1);
        chk("stall_data", 32'(tx_data), 32'(pd));
      end
      if (tx_valid && tx_ready) rxq.push_back(tx_data);
    end
    pv = tx_valid;
    pr = tx_ready;
    pd = tx_data;
  end

  task automatic wait_bytes(input int n, input int budget);
    int t;
    t = 0;
    while (rxq.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk("wait_bytes", 32'(rxq.size() >= n), 32'd1);
  endtask

  task automatic expect_frame(input string tag, input logic [31:0] w,
                              input bit use_hand, input logic [7:0] cs_hand);
    logic [7:0] b[NB+3];
    logic [7:0] cs;
    b[0] = 8'hA5;
    b[1] = exp_seq;
    cs   = exp_seq;
    for (int i = 0; i < NB; i++) begin
      b[2+i] = w[31-8*i -: 8];
      cs     = cs ^ b[2+i];
    end
    b[NB+2] = use_hand ? cs_hand : cs;
    wait_bytes(NB + 3, 400);
    for (int i = 0; i < NB + 3; i++) begin
      if (rxq.size() > 0) chk($sformatf("%s_b%0d", tag, i), 32'(rxq.pop_front()), 32'(b[i]));
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    rxq.delete();
    exp_seq = 8'h00;
    reset   = 1'b1;
    mon_en  = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset     = 1'b0;
    drain_en  = 1'b0;
    fifo_dout = 32'h0;
    fifo_empty = 1'b1;
    tx_ready  = 1'b0;
    mon_en    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Single frame, ready always high.
    ready_lvl = 1'b1;
    drain_en  = 1'b1;
    fq.push_back(32'h12345678);
    expect_frame("t1", 32'h12345678, 1'b1, 8'h08);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_rd_pulses", 32'(rd_cnt), 32'd1);

    // Two queued words, back to back.
    reset_dut();
    r = rd_cnt;
    fq.push_back(32'hDEADBEEF);
    fq.push_back(32'h00000001);
    expect_frame("t2a", 32'hDEADBEEF, 1'b1, 8'h22);
    expect_frame("t2b", 32'h00000001, 1'b1, 8'h00);
    @(negedge clk);
    chk("t2_rd_pulses", 32'(rd_cnt - r), 32'd2);
    chk("t2_period", 32'(rd_time_last - rd_time_prev), 32'(NB + 6));
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Random back-pressure.
    r = rd_cnt;
    stall_mode = 1'b1;
    fq.push_back(32'hA1B2C3D4);
    fq.push_back(32'h0F1E2D3C);
    fq.push_back(32'hFFFFFFFF);
    expect_frame("t3a", 32'hA1B2C3D4, 1'b1, 8'h02 ^ 8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4);
    expect_frame("t3b", 32'h0F1E2D3C, 1'b0, 8'h00);
    expect_frame("t3c", 32'hFFFFFFFF, 1'b1, 8'h04);
    stall_mode = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_rd_pulses", 32'(rd_cnt - r), 32'd3);

    // drain_en dropped mid-frame.
    fq.push_back(32'h55AA55AA);
    fq.push_back(32'h01020304);
    wait_bytes(3, 100);
    drain_en = 1'b0;
    expect_frame("t4a", 32'h55AA55AA, 1'b1, 8'h05);
    r = rd_cnt;
    repeat (20) @(negedge clk);
    chk("t4_no_pop", 32'(rd_cnt), 32'(r));
    chk("t4_no_bytes", 32'(rxq.size()), 32'd0);
    chk("t4_idle_valid", 32'(tx_valid), 32'd0);
    drain_en = 1'b1;
    expect_frame("t4b", 32'h01020304, 1'b1, 8'h06 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);

    // Sequence wrap across 257 frames, then idle on empty.
    reset_dut();
    for (int i = 0; i < 257; i++) fq.push_back(32'hC0FFEE00 ^ (i * 32'h01010101));
    for (int i = 0; i < 257; i++) begin
      expect_frame($sformatf("t5f%0d", i), 32'hC0FFEE00 ^ (i * 32'h01010101), 1'b0, 8'h00);
    end
    @(negedge clk);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd257);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_empty_rd", 32'(fifo_rd), 32'd0);
      chk("t5_empty_valid", 32'(tx_valid), 32'd0);
    end

    // Asynchronous reset while the SEQ byte is presented.
    fq.push_back(32'h13579BDF);
    wait_bytes(1, 100);
    #3;
    reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("t6_valid", 32'(tx_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rd", 32'(fifo_rd), 32'd0);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rxq.delete();
    fq.delete();
    exp_seq = 8'h00;
    reset   = 1'b1;
    mon_en  = 1'b1;
    fq.push_back(32'hCAFEF00D);
    expect_frame("t6", 32'hCAFEF00D, 1'b1, 8'hC9);
    @(negedge clk);
    chk("t6_frame_cnt_after", 32'(frame_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_drain_serializer.md
Name: trace_drain_serializer

Overview:
- Downstream consumer of the 512-deep trace buffer.
- Pops captured Fpay-bit trace words and wraps each one in a fixed-length byte frame: SYNC, SEQ, payload bytes, CHECKSUM.
- Emits the frames on a byte-wide valid/ready stream toward the host link (UART/JTAG bridge).
- Gives the host a lossless, self-synchronising readout of the trace captured from the tiles.

Parameters:
- Fpay, 32, trace word width; must be a multiple of 8 and at least 8.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- NB, Fpay/8, payload bytes per frame (derived localparam).

Ports:
- clk  input  1  single clock (same clock as trace buffer).
- reset  input  1  asynchronous, active-low reset.
- drain_en  input  1  level; 1 permits new frames to start.
- fifo_empty  input  1  trace buffer empty flag.
- fifo_rd  output  1  one-cycle pop strobe to trace buffer rd_en.
- fifo_dout  input  Fpay  trace buffer data; valid exactly 1 cycle after fifo_rd.
- tx_data  output  8  frame byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  sink accepts byte when tx_valid && tx_ready.
- busy  output  1  high from pop until CHECKSUM accepted.
- frame_cnt  output  16  frames fully sent; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, async): state=IDLE; fifo_rd=0, tx_valid=0, tx_data=0, busy=0, frame_cnt=0, seq=0, csum=0, word register=0, byte index=0.
- States: IDLE, POP, LOAD, SYNC, SEQ, DATA, CSUM.
- IDLE:
  - If drain_en && !fifo_empty: fifo_rd=1 for exactly one cycle (registered), go to POP.
  - Otherwise stay; fifo_rd=0.
- POP: fifo_rd=0, busy=1; go to LOAD.
- LOAD (cycle after POP):
  - Capture fifo_dout into word register.
  - Clear csum and byte index.
  - Drive tx_data=SYNC_BYTE, tx_valid=1; go to SYNC.
  - Pop-to-first-byte latency is 2 cycles after the fifo_rd cycle.
- SYNC: on accept, tx_data=seq, csum=seq; go to SEQ.
- SEQ: on accept, tx_data=word[Fpay-1:Fpay-8] (MSB byte first), byte index=0; go to DATA.
- DATA:
  - On each accept, csum ^= current byte and byte index increments.
  - tx_data = next lower byte of the word.
  - After byte NB-1 is accepted, tx_data = csum ^ last byte; go to CSUM.
- CSUM: on accept:
  - tx_valid=0, busy=0.
  - seq increments mod 256 (8'hFF to 8'h00).
  - frame_cnt increments unless already 16'hFFFF.
  - Return to IDLE.
- Handshake rules:
  - tx_data and tx_valid change only on an accept cycle or on entry from LOAD.
  - While tx_valid=1 && tx_ready=0, tx_data is held stable for any number of cycles.
  - tx_valid is never dropped without an accept.
- Frame timing:
  - Checksum = XOR of the SEQ byte and all payload bytes; SYNC is excluded.
  - Frame length is NB+3 bytes.
  - Back-to-back: the earliest next fifo_rd is in the IDLE cycle following the CSUM accept. Minimum frame period is NB+6 cycles with tx_ready held high.
- drain_en:
  - Sampled only in IDLE.
  - Deassertion mid-frame does not truncate the frame; it completes, then the block stays in IDLE.
- fifo_empty:
  - Sampled only in IDLE.
  - Never pops when empty; fifo_rd is never asserted outside IDLE→POP.
- Reset mid-frame: output is abandoned immediately (tx_valid=0); seq and frame_cnt return to 0; the popped word is lost. The host resynchronises on SYNC.
- tx_ready asserted while tx_valid=0 has no effect.

Test Plan:
- Reset, drain_en=1, fifo_empty=0, fifo_dout=32'h12345678 in the cycle after fifo_rd, tx_ready=1 → bytes A5,00,12,34,56,78,csum=00^12^34^56^78=08. fifo_rd is a single pulse. frame_cnt=1, busy low after the last accept.
- Two queued words (32'hDEADBEEF, then 32'h00000001), tx_ready=1 → frames with SEQ 00 and 01. Second fifo_rd occurs exactly 1 cycle after the first frame's CSUM accept.
- tx_ready toggled pseudo-randomly with 0-5 stall cycles per byte → tx_data stable throughout each stall; byte sequence identical to the no-stall case; no extra fifo_rd.
- drain_en dropped in the DATA state with fifo_empty=0 → current frame completes with a correct CSUM; no further fifo_rd while drain_en=0; draining resumes when drain_en=1.
- Preload seq by sending 256 frames → the 257th frame has SEQ=00. frame_cnt=257. fifo_empty=1 in IDLE keeps fifo_rd=0 and tx_valid=0.
- Assert reset=0 asynchronously in the middle of the SEQ byte → tx_valid, busy and fifo_rd go to 0 immediately. After release, the next frame starts with A5,00 and frame_cnt=1.
